// File: rtl/sysid_ext_pkg.sv
// sysid_ext_pkg: shared constants for the system-ID / uptime peripheral.
//   - word addresses of the eight-entry register map
//   - CTRL register bit positions (RUN, CLEAR, OVF)
//   - helper that assembles the CTRL readback word
package sysid_ext_pkg;

  localparam logic [2:0] ADDR_ID        = 3'd0;
  localparam logic [2:0] ADDR_TIMESTAMP = 3'd1;
  localparam logic [2:0] ADDR_UPTIME_LO = 3'd2;
  localparam logic [2:0] ADDR_UPTIME_HI = 3'd3;
  localparam logic [2:0] ADDR_CTRL      = 3'd4;
  localparam logic [2:0] ADDR_TICK_DIV  = 3'd5;
  localparam logic [2:0] ADDR_SCRATCH0  = 3'd6;
  localparam logic [2:0] ADDR_SCRATCH1  = 3'd7;

  localparam int CTRL_RUN   = 0;
  localparam int CTRL_CLEAR = 1;
  localparam int CTRL_OVF   = 2;

  // CLEAR is self-clearing, so it always reads back as 0.
  function automatic logic [31:0] ctrl_word(input logic run, input logic ovf);
    return {29'd0, ovf, 1'b0, run};
  endfunction

endpackage

// File: rtl/sysid_ext_if.sv
// sysid_ext_if: Avalon-MM style register bus for sysid_ext.
//   address/read/write/writedata : master -> slave
//   readdata/readdatavalid       : slave -> master (one-cycle read latency)
interface sysid_ext_if;
  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        readdatavalid;

  modport master (
    output address, read, write, writedata,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/sysid_uptime_counter.sv
// sysid_uptime_counter: prescaled free-running uptime counter.
//   clock, reset : system clock, async active-high reset
//   run          : prescaler/uptime advance enable
//   clear        : zero prescaler and uptime on this edge (tick still reported)
//   uptime       : current uptime count
//   tick         : registered pulse, high in the cycle the new uptime is visible
//   wrap         : combinational, high when this edge rolls uptime from all-ones
module sysid_uptime_counter
  import sysid_ext_pkg::*;
#(
  parameter int TICK_DIV     = 1000,
  parameter int UPTIME_WIDTH = 48
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    run,
  input  logic                    clear,
  output logic [UPTIME_WIDTH-1:0] uptime,
  output logic                    tick,
  output logic                    wrap
);

  localparam int             PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]           presc_r;
  logic [PW-1:0]           presc_nxt_s;
  logic [UPTIME_WIDTH-1:0] uptime_r;
  logic [UPTIME_WIDTH-1:0] uptime_nxt_s;
  logic                    tick_r;
  logic                    term_s;

  // Next-state for prescaler and uptime; clear overrides the increment.
  always_comb begin
    term_s       = run && (presc_r == PRESC_LAST);
    wrap         = term_s && (uptime_r == {UPTIME_WIDTH{1'b1}});
    presc_nxt_s  = presc_r;
    uptime_nxt_s = uptime_r;
    if (clear) begin
      presc_nxt_s  = {PW{1'b0}};
      uptime_nxt_s = {UPTIME_WIDTH{1'b0}};
    end else if (term_s) begin
      presc_nxt_s  = {PW{1'b0}};
      uptime_nxt_s = uptime_r + UPTIME_WIDTH'(1);
    end else if (run) begin
      presc_nxt_s  = presc_r + PW'(1);
    end else begin
      presc_nxt_s  = presc_r;
    end
  end

  // Counter state; tick is registered alongside the incremented uptime.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc_r  <= {PW{1'b0}};
      uptime_r <= {UPTIME_WIDTH{1'b0}};
      tick_r   <= 1'b0;
    end else begin
      presc_r  <= presc_nxt_s;
      uptime_r <= uptime_nxt_s;
      tick_r   <= term_s;
    end
  end

  assign uptime = uptime_r;
  assign tick   = tick_r;

endmodule

// File: rtl/sysid_ext.sv
// sysid_ext: system ID, build timestamp and uptime peripheral.
//   clock, reset : system clock, async active-high reset
//   bus          : register bus slave (8 words, registered read data)
//   tick         : one-cycle pulse on every uptime increment
// Reading UPTIME_LO snapshots the upper uptime bits into a shadow that
// UPTIME_HI returns, so a LO-then-HI read pair is coherent.
module sysid_ext
  import sysid_ext_pkg::*;
#(
  parameter logic [31:0] SYSTEM_ID    = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP    = 32'h0000_0000,
  parameter int          TICK_DIV     = 1000,
  parameter int          UPTIME_WIDTH = 48
) (
  input  logic        clock,
  input  logic        reset,
  sysid_ext_if.slave  bus,
  output logic        tick
);

  localparam int HI_W = UPTIME_WIDTH - 32;

  logic                    run_r;
  logic                    ovf_r;
  logic [HI_W-1:0]         shadow_r;
  logic [31:0]             scratch0_r;
  logic [31:0]             scratch1_r;
  logic [31:0]             readdata_r;
  logic                    readdatavalid_r;
  logic                    ctrl_wr_s;
  logic                    clear_s;
  logic                    wrap_s;
  logic [UPTIME_WIDTH-1:0] uptime_s;
  logic [31:0]             rd_mux_s;

  sysid_uptime_counter #(
    .TICK_DIV     (TICK_DIV),
    .UPTIME_WIDTH (UPTIME_WIDTH)
  ) u_counter (
    .clock  (clock),
    .reset  (reset),
    .run    (run_r),
    .clear  (clear_s),
    .uptime (uptime_s),
    .tick   (tick),
    .wrap   (wrap_s)
  );

  // Write decode for CTRL and the CLEAR strobe.
  always_comb begin
    ctrl_wr_s = bus.write && (bus.address == ADDR_CTRL);
    clear_s   = ctrl_wr_s && bus.writedata[CTRL_CLEAR];
  end

  // Read data multiplexer (pre-write values, so read+write returns old data).
  always_comb begin
    rd_mux_s = 32'h0000_0000;
    case (bus.address)
      ADDR_ID:        rd_mux_s = SYSTEM_ID;
      ADDR_TIMESTAMP: rd_mux_s = TIMESTAMP;
      ADDR_UPTIME_LO: rd_mux_s = uptime_s[31:0];
      ADDR_UPTIME_HI: rd_mux_s = 32'(shadow_r);
      ADDR_CTRL:      rd_mux_s = ctrl_word(run_r, ovf_r);
      ADDR_TICK_DIV:  rd_mux_s = 32'(TICK_DIV);
      ADDR_SCRATCH0:  rd_mux_s = scratch0_r;
      ADDR_SCRATCH1:  rd_mux_s = scratch1_r;
      default:        rd_mux_s = 32'h0000_0000;
    endcase
  end

  // CTRL, shadow and scratch registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      run_r      <= 1'b1;
      ovf_r      <= 1'b0;
      shadow_r   <= {HI_W{1'b0}};
      scratch0_r <= 32'h0000_0000;
      scratch1_r <= 32'h0000_0000;
    end else begin
      if (ctrl_wr_s) begin
        run_r <= bus.writedata[CTRL_RUN];
      end
      // A wrap on the same edge as the W1C keeps OVF set.
      if (wrap_s) begin
        ovf_r <= 1'b1;
      end else if (ctrl_wr_s && bus.writedata[CTRL_OVF]) begin
        ovf_r <= 1'b0;
      end
      if (clear_s) begin
        shadow_r <= {HI_W{1'b0}};
      end else if (bus.read && (bus.address == ADDR_UPTIME_LO)) begin
        shadow_r <= uptime_s[UPTIME_WIDTH-1:32];
      end
      if (bus.write && (bus.address == ADDR_SCRATCH0)) begin
        scratch0_r <= bus.writedata;
      end
      if (bus.write && (bus.address == ADDR_SCRATCH1)) begin
        scratch1_r <= bus.writedata;
      end
    end
  end

  // Read pipeline register; readdata holds between reads.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      readdata_r      <= 32'h0000_0000;
      readdatavalid_r <= 1'b0;
    end else begin
      readdatavalid_r <= bus.read;
      if (bus.read) begin
        readdata_r <= rd_mux_s;
      end
    end
  end

  assign bus.readdata      = readdata_r;
  assign bus.readdatavalid = readdatavalid_r;

endmodule
